// File: rtl/uart_host_pkg.sv
// Shared types and constants for the 8251 host sequencer: main FSM states, bus phases,
// status bit positions and the fixed control command bytes.
package uart_host_pkg;

  typedef enum logic [3:0] {
    INIT_Z0, INIT_Z1, INIT_Z2, INIT_IR, INIT_MODE, INIT_CMD,
    POLL, RX_RD, TX_WR, ERR_CLR
  } main_state_t;

  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD} bus_phase_t;

  localparam int STAT_TXRDY = 0;
  localparam int STAT_RXRDY = 1;
  localparam int STAT_PE    = 3;
  localparam int STAT_OE    = 4;
  localparam int STAT_FE    = 5;

  localparam logic [7:0] CMD_INT_RESET = 8'h40;
  localparam logic [7:0] CMD_ERR_RESET = 8'h10;

  function automatic logic stat_err(input logic [7:0] status);
    return status[STAT_PE] | status[STAT_OE] | status[STAT_FE];
  endfunction

endpackage

// File: rtl/uart_host_bus.sv
// Single 8251 bus access: SETUP, STROBE_CYCLES of WR_n/RD_n low, HOLD, then a one-clock done.
// All pin outputs are registered so the bus never glitches.
module uart_host_bus
  import uart_host_pkg::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       we,
  input  logic       cd,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       cd_pin,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in
);

  localparam logic [3:0] LAST = 4'(STROBE_CYCLES - 1);

  bus_phase_t phase;
  logic [3:0] cnt;
  logic       we_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase  <= PH_IDLE;
      cnt    <= '0;
      we_q   <= 1'b0;
      done   <= 1'b0;
      rdata  <= '0;
      cs_n   <= 1'b1;
      wr_n   <= 1'b1;
      rd_n   <= 1'b1;
      cd_pin <= 1'b0;
      d_out  <= '0;
      d_oe   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (phase)
        PH_IDLE: if (req) begin
          phase  <= PH_SETUP;
          we_q   <= we;
          cs_n   <= 1'b0;
          cd_pin <= cd;
          d_out  <= we ? wdata : 8'h00;
          d_oe   <= we;
        end
        PH_SETUP: begin
          phase <= PH_STROBE;
          cnt   <= '0;
          wr_n  <= !we_q;
          rd_n  <= we_q;
        end
        // read data is captured on the edge that ends the last strobe clock
        PH_STROBE: if (cnt == LAST) begin
          phase <= PH_HOLD;
          wr_n  <= 1'b1;
          rd_n  <= 1'b1;
          if (!we_q) rdata <= d_in;
        end else begin
          cnt <= cnt + 4'd1;
        end
        PH_HOLD: begin
          phase  <= PH_IDLE;
          done   <= 1'b1;
          cs_n   <= 1'b1;
          cd_pin <= 1'b0;
          d_out  <= '0;
          d_oe   <= 1'b0;
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_host_seq.sv
// 8251 USART host sequencer: init writes, status polling, RX/TX byte moves and a TX FIFO.
// Define UART_HOST_SEQ_ERR_CHECK_EN to react to PE/OE/FE with err_pulse and an error-reset write.
module uart_host_seq
  import uart_host_pkg::*;
#(
  parameter logic [7:0] MODE_WORD     = 8'h4E,
  parameter logic [7:0] CMD_WORD      = 8'h37,
  parameter int         STROBE_CYCLES = 2,
  parameter int         TX_DEPTH      = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       init_done,
  output logic       err_pulse,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic       CD,
  output logic [7:0] D_out,
  output logic       D_oe,
  input  logic [7:0] D_in
);

  localparam int AW = $clog2(TX_DEPTH);

  main_state_t state;
  logic        issued;
  logic        req, req_we, req_cd;
  logic [7:0]  req_wdata;
  logic        bus_done;
  logic [7:0]  bus_rdata;
  logic        acc_we, acc_cd;
  logic [7:0]  acc_wdata;

  logic [7:0]  mem [TX_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic [7:0]  fifo_head;

  // extra pointer MSB distinguishes full from empty when the index bits match
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign tx_ready  = init_done && !full;
  assign push      = tx_valid && tx_ready;
  assign pop       = bus_done && (state == TX_WR);
  assign fifo_head = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    acc_we    = 1'b1;
    acc_cd    = 1'b1;
    acc_wdata = 8'h00;
    case (state)
      INIT_IR:   acc_wdata = CMD_INT_RESET;
      INIT_MODE: acc_wdata = MODE_WORD;
      INIT_CMD:  acc_wdata = CMD_WORD;
      POLL:      acc_we    = 1'b0;
      RX_RD: begin
        acc_we = 1'b0;
        acc_cd = 1'b0;
      end
      TX_WR: begin
        acc_cd    = 1'b0;
        acc_wdata = fifo_head;
      end
      ERR_CLR:   acc_wdata = CMD_WORD | CMD_ERR_RESET;
      default:   acc_wdata = 8'h00;
    endcase
  end

`ifdef UART_HOST_SEQ_ERR_CHECK_EN
  logic err_q;
  assign err_pulse = err_q;
`else
  assign err_pulse = 1'b0;
`endif

  // each state issues exactly one access, then advances when the bus reports done
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= INIT_Z0;
      issued    <= 1'b0;
      req       <= 1'b0;
      req_we    <= 1'b0;
      req_cd    <= 1'b0;
      req_wdata <= '0;
      init_done <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
`ifdef UART_HOST_SEQ_ERR_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      req <= 1'b0;
`ifdef UART_HOST_SEQ_ERR_CHECK_EN
      err_q <= 1'b0;
`endif
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (!issued) begin
        issued    <= 1'b1;
        req       <= 1'b1;
        req_we    <= acc_we;
        req_cd    <= acc_cd;
        req_wdata <= acc_wdata;
      end else if (bus_done) begin
        issued <= 1'b0;
        case (state)
          INIT_Z0:   state <= INIT_Z1;
          INIT_Z1:   state <= INIT_Z2;
          INIT_Z2:   state <= INIT_IR;
          INIT_IR:   state <= INIT_MODE;
          INIT_MODE: state <= INIT_CMD;
          INIT_CMD: begin
            state     <= POLL;
            init_done <= 1'b1;
          end
          POLL:
`ifdef UART_HOST_SEQ_ERR_CHECK_EN
            if (stat_err(bus_rdata)) begin
              err_q <= 1'b1;
              state <= ERR_CLR;
            end else
`endif
            if (bus_rdata[STAT_RXRDY] && !rx_valid) state <= RX_RD;
            else if (bus_rdata[STAT_TXRDY] && !empty) state <= TX_WR;
            else state <= POLL;
          RX_RD: begin
            rx_data  <= bus_rdata;
            rx_valid <= 1'b1;
            state    <= POLL;
          end
          default:   state <= POLL;
        endcase
      end
    end
  end

  uart_host_bus #(.STROBE_CYCLES(STROBE_CYCLES)) u_bus (
    .clk    (CLK),
    .rst    (RESET),
    .req    (req),
    .we     (req_we),
    .cd     (req_cd),
    .wdata  (req_wdata),
    .done   (bus_done),
    .rdata  (bus_rdata),
    .cs_n   (CS_n),
    .wr_n   (WR_n),
    .rd_n   (RD_n),
    .cd_pin (CD),
    .d_out  (D_out),
    .d_oe   (D_oe),
    .d_in   (D_in)
  );

endmodule

// File: tb/tb_uart_host_seq.sv
// Bench for uart_host_seq: an 8251 model answers the bus, a monitor scoreboards every access
// and RX handshake against queues filled by the stimulus process.
module tb_uart_host_seq;

  localparam logic [7:0] MODE_WORD     = 8'h4E;
  localparam logic [7:0] CMD_WORD      = 8'h37;
  localparam int         STROBE_CYCLES = 2;
  localparam int         TX_DEPTH      = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       init_done, err_pulse, CS_n, WR_n, RD_n, CD, D_oe;
  logic [7:0] D_out;
  logic [7:0] D_in = 8'h00;

  always #5 CLK = ~CLK;

  uart_host_seq #(
    .MODE_WORD(MODE_WORD), .CMD_WORD(CMD_WORD),
    .STROBE_CYCLES(STROBE_CYCLES), .TX_DEPTH(TX_DEPTH)
  ) dut (
    .CLK(CLK), .RESET(RESET), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .init_done(init_done),
    .err_pulse(err_pulse), .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n), .CD(CD),
    .D_out(D_out), .D_oe(D_oe), .D_in(D_in)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference expectations
  logic [7:0] exp_ctrl [6];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] rx_q[$];
  bit         acc_log[$];
  bit         model_txrdy = 1'b0;
  logic [2:0] err_bits = 3'b000;

  // monitor state
  bit         in_acc = 1'b0;
  int         idle_cnt = 0;
  int         low_cnt = 0;
  bit         acc_we, acc_cd, doe_any, doe_all;
  logic [7:0] acc_wd, acc_rd;
  bit         last_was_status = 1'b0;
  logic [7:0] last_status = 8'h00;
  int         n_ctrl = 0;
  int         init_wait = 0;
  bit         err_expected = 1'b0;
  bit         prev_err = 1'b0;
  int         n_dwr = 0, n_drd = 0, n_errclr = 0, n_errpulse = 0;

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] model_status();
    return {2'b00, err_bits, 1'b0, (rx_q.size() != 0), model_txrdy};
  endfunction

  task automatic finish_access();
    chk("strobe_len", low_cnt, STROBE_CYCLES);
    chk("d_oe_window", acc_we ? doe_all : doe_any, acc_we ? 1 : 0);
    if (acc_we) begin
      if (acc_cd) begin
        if (n_ctrl < 6) begin
          chk("init_write", acc_wd, exp_ctrl[n_ctrl]);
          chk("init_done_early", init_done, 0);
          n_ctrl++;
          if (n_ctrl == 6) init_wait = 2;
        end else begin
          chk("ctrl_write_expected", err_expected, 1);
          chk("err_reset_byte", acc_wd, CMD_WORD | 8'h10);
          err_expected = 1'b0;
          err_bits = 3'b000;
          n_errclr++;
        end
      end else begin
        chk("tx_after_status", last_was_status && last_status[0], 1);
        if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
        else chk("tx_data", acc_wd, exp_tx.pop_front());
        acc_log.push_back(1'b1);
        n_dwr++;
      end
      last_was_status = 1'b0;
    end else if (acc_cd) begin
      last_status = acc_rd;
      last_was_status = 1'b1;
    end else begin
      chk("rx_after_status", last_was_status && last_status[1], 1);
      chk("rx_read_while_full", rx_valid, 0);
      exp_rx.push_back(acc_rd);
      if (rx_q.size() != 0) void'(rx_q.pop_front());
      acc_log.push_back(1'b0);
      n_drd++;
      last_was_status = 1'b0;
    end
  endtask

  // bus/handshake monitor and 8251 model, working on the falling edge
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET) begin
        in_acc = 1'b0; idle_cnt = 0; n_ctrl = 0; init_wait = 0;
        last_was_status = 1'b0; err_expected = 1'b0; prev_err = 1'b0;
        D_in = 8'h00;
      end else begin
        if (init_wait > 0) begin
          init_wait--;
          if (init_wait == 0) chk("init_done_set", init_done, 1);
        end
        D_in = CD ? model_status() : ((rx_q.size() != 0) ? rx_q[0] : 8'h00);
        if (!CS_n) begin
          if (!in_acc) begin
            chk("idle_gap", idle_cnt >= 1, 1);
            in_acc = 1'b1; low_cnt = 0; acc_we = 1'b0; doe_any = 1'b0; doe_all = 1'b1;
          end
          acc_cd = CD;
          doe_any = doe_any | D_oe;
          doe_all = doe_all & D_oe;
          if (!WR_n) begin low_cnt++; acc_we = 1'b1; acc_wd = D_out; end
          if (!RD_n) begin low_cnt++; acc_rd = D_in; end
          idle_cnt = 0;
        end else begin
          if (in_acc) finish_access();
          in_acc = 1'b0;
          idle_cnt++;
        end
        if (rx_valid && rx_ready) begin
          if (exp_rx.size() == 0) chk("rx_unexpected", 1, 0);
          else chk("rx_data", rx_data, exp_rx.pop_front());
        end
        if (err_pulse) begin
          n_errpulse++;
          err_expected = 1'b1;
          chk("err_pulse_width", prev_err, 0);
          chk("err_pulse_cause", err_bits != 3'b000, 1);
        end
        prev_err = err_pulse;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic check_reset_state();
    chk("rst_cs_n", CS_n, 1);       chk("rst_wr_n", WR_n, 1);
    chk("rst_rd_n", RD_n, 1);       chk("rst_cd", CD, 0);
    chk("rst_d_oe", D_oe, 0);       chk("rst_d_out", D_out, 0);
    chk("rst_tx_ready", tx_ready, 0); chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0); chk("rst_init_done", init_done, 0);
    chk("rst_err_pulse", err_pulse, 0);
  endtask

  task automatic push_byte(input logic [7:0] b, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tx_ready) begin
        tx_data = b; tx_valid = 1'b1;
        exp_tx.push_back(b);
        @(posedge CLK); #1;
        tx_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic wait_init(input int budget);
    for (int i = 0; i < budget && !init_done; i++) begin @(posedge CLK); #1; end
    chk("init_timeout", init_done, 1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < budget; i++) begin
      idle = (exp_tx.size() == 0) && (exp_rx.size() == 0) && (rx_q.size() == 0) && !rx_valid;
      if (idle) break;
      @(posedge CLK); #1;
    end
    chk(name, idle, 1);
  endtask

  initial begin
    bit ok;
    int d0, l0, e0, p0, acc;
    exp_ctrl = '{8'h00, 8'h00, 8'h00, 8'h40, MODE_WORD, CMD_WORD};

    repeat (3) @(posedge CLK);
    #1;
    check_reset_state();
    RESET = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("tx_ready_before_init", tx_ready, 0);
    wait_init(400);

    // two queued bytes with the transmitter ready
    model_txrdy = 1'b1;
    push_byte(8'hA5, 50, ok);
    push_byte(8'h3C, 50, ok);
    wait_drain(400, "drain_two_bytes");
    chk("two_writes", n_dwr, 2);

    // status 03 with a byte queued: read must come first
    model_txrdy = 1'b0; rx_ready = 1'b1;
    push_byte(8'h77, 50, ok);
    repeat (20) @(posedge CLK);
    #1;
    l0 = acc_log.size();
    rx_q.push_back(8'h5A);
    model_txrdy = 1'b1;
    wait_drain(400, "drain_rx_tx");
    chk("read_before_write", (acc_log.size() > l0) ? acc_log[l0] : 1'b1, 0);

    // consumer stalls: no further read while rx_data is held
    rx_ready = 1'b0;
    d0 = n_drd;
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    for (int i = 0; i < 200 && !rx_valid; i++) begin @(posedge CLK); #1; end
    repeat (60) @(posedge CLK);
    #1;
    chk("no_read_while_held", n_drd, d0 + 1);
    rx_ready = 1'b1;
    @(posedge CLK); #1;
    rx_ready = 1'b0;
    for (int i = 0; i < 200 && n_drd < d0 + 2; i++) begin @(posedge CLK); #1; end
    chk("read_after_take", n_drd, d0 + 2);
    rx_ready = 1'b1;
    wait_drain(200, "drain_stall");

    // FIFO fill with the transmitter busy
    model_txrdy = 1'b0;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      push_byte(8'(8'hC0 + i), 5, ok);
      if (ok) acc++;
    end
    chk("fifo_accepted", acc, TX_DEPTH);
    chk("fifo_full_ready", tx_ready, 0);
    model_txrdy = 1'b1;
    wait_drain(800, "drain_fifo");

    // error bits in status (TxRDY + OE)
    e0 = n_errclr; p0 = n_errpulse;
    err_bits = 3'b010;
`ifdef UART_HOST_SEQ_ERR_CHECK_EN
    for (int i = 0; i < 300 && n_errclr == e0; i++) begin @(posedge CLK); #1; end
    chk("err_clear_write", n_errclr, e0 + 1);
    chk("err_pulse_count", n_errpulse, p0 + 1);
`else
    d0 = n_dwr;
    push_byte(8'h99, 50, ok);
    for (int i = 0; i < 300 && n_dwr == d0; i++) begin @(posedge CLK); #1; end
    chk("err_ignored_write", n_dwr, d0 + 1);
    chk("err_pulse_count", n_errpulse, p0);
    err_bits = 3'b000;
`endif
    wait_drain(300, "drain_err");

    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        push_byte(8'($urandom), 1, ok);
        if (!ok) void'(exp_tx.size());
      end
      if ($urandom_range(0, 3) == 0 && rx_q.size() < 4) rx_q.push_back(8'($urandom));
      model_txrdy = 1'($urandom_range(0, 1));
      rx_ready    = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8)) @(posedge CLK);
      #1;
    end
    model_txrdy = 1'b1; rx_ready = 1'b1;
    wait_drain(5000, "drain_random");

    // reset in the middle of a data write strobe
    push_byte(8'hC3, 50, ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK); #1;
      if (!WR_n && !CD) begin ok = 1'b1; break; end
    end
    chk("strobe_reached", ok, 1);
    #2;
    RESET = 1'b1;
    exp_tx.delete(); exp_rx.delete(); rx_q.delete();
    #1;
    chk("abort_wr_n", WR_n, 1);
    chk("abort_cs_n", CS_n, 1);
    repeat (2) @(posedge CLK);
    #1;
    check_reset_state();
    RESET = 1'b0;
    wait_init(400);
    push_byte(8'h5E, 50, ok);
    rx_q.push_back(8'hE7);
    wait_drain(400, "drain_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
